// File: rtl/platform_pkg.sv
// platform_pkg: shared sizes, FSM states and table entry type for the platform table
package platform_pkg;
    localparam int N_PLAT = 16;
    localparam int SCREEN_H = 480;
    localparam int PLAT_HW = 4;
    localparam int PLAT_HH = 4;

    typedef enum logic [2:0] {INIT, WAIT, CHECK, SCROLL, DONE} state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } plat_pos_t;
endpackage

// File: rtl/plat_lfsr.sv
// plat_lfsr: free-running 16-bit Galois LFSR (mask 0xB400, shift right); exposes the low 9 bits
module plat_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic [8:0] rnd
);
    logic [15:0] lfsr;

    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) lfsr <= SEED;
        else lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    assign rnd = lfsr[8:0];
endmodule

// File: rtl/platform_table.sv
// platform_table: platform position table -- random initial layout, per-frame landing check,
// scroll and respawn, with frame strobes synchronised from frame_clk
module platform_table
    import platform_pkg::*;
#(
    parameter int          SPACING   = 30,
    parameter int          BASE_Y    = 465,
    parameter int          X_MARGIN  = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic [9:0]           BallX,
    input  logic [9:0]           BallY,
    input  logic [9:0]           Ball_size,
    input  logic                 ball_falling,
    input  logic [3:0]           scroll_amt,
    output logic [N_PLAT*10-1:0] PlatX,
    output logic [N_PLAT*10-1:0] PlatY,
    output logic                 table_valid,
    output logic                 land,
    output logic [9:0]           land_y,
    output logic                 frame_done,
    output logic                 overrun
);
    localparam int IW = $clog2(N_PLAT);

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [2:0]      sync;
    logic            fe, pending, hit, last, start, hit_now;
    logic [3:0]      scroll;
    logic [8:0]      rnd;
    logic [9:0]      rand_x, dx;
    logic [10:0]     ny;
    logic [11:0]     by;
    plat_pos_t       tbl [N_PLAT];
    plat_pos_t       cur;

    plat_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.Clk(Clk), .Reset(Reset), .rnd(rnd));

    assign fe     = sync[1] & ~sync[2];
    assign cur    = tbl[idx];
    assign last   = idx == IW'(N_PLAT - 1);
    // a queued edge restarts straight out of DONE so back-to-back frames lose no cycle
    assign start  = (state == WAIT && (fe || pending)) || (state == DONE && pending);
    assign rand_x = 10'(X_MARGIN) + {1'b0, rnd};
    assign dx     = BallX >= cur.x ? BallX - cur.x : cur.x - BallX;
    assign by     = {2'b0, BallY} + {2'b0, Ball_size};
    assign ny     = {1'b0, cur.y} + {7'b0, scroll};
    // Y window compared without subtraction so platforms near the top never go negative
    assign hit_now = ball_falling && ({1'b0, dx} <= {1'b0, Ball_size} + 11'(PLAT_HW))
                     && (by + 12'(PLAT_HH) >= {2'b0, cur.y}) && (by <= {2'b0, cur.y} + 12'(PLAT_HH));

    always_comb begin
        state_n = state;
        idx_n = '0;
        case (state)
            INIT:    state_n = last ? WAIT : INIT;
            WAIT:    state_n = start ? CHECK : WAIT;
            CHECK:   state_n = last ? SCROLL : CHECK;
            SCROLL:  state_n = last ? DONE : SCROLL;
            DONE:    state_n = pending ? CHECK : WAIT;
            default: state_n = INIT;
        endcase
        if (state inside {INIT, CHECK, SCROLL}) idx_n = last ? '0 : idx + 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            state <= INIT;
            idx <= '0;
        end else begin
            state <= state_n;
            idx <= idx_n;
        end

    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            sync <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
            table_valid <= 1'b0;
            land <= 1'b0;
            land_y <= '0;
            frame_done <= 1'b0;
            hit <= 1'b0;
            scroll <= '0;
            for (int i = 0; i < N_PLAT; i++) tbl[i] <= '0;
        end else begin
            sync <= {sync[1:0], frame_clk};
            frame_done <= state == SCROLL && last;
            land <= state == SCROLL && last && hit;
            if (start) begin
                pending <= fe && state == DONE;
                hit <= 1'b0;
                scroll <= scroll_amt;
            end else if (fe && state != WAIT) begin
                pending <= 1'b1;
                overrun <= overrun | pending;
            end
            case (state)
                INIT: begin
                    tbl[idx].x <= rand_x;
                    tbl[idx].y <= 10'(BASE_Y - SPACING * int'(idx));
                    if (last) table_valid <= 1'b1;
                end
                CHECK: if (hit_now && !hit) begin
                    hit <= 1'b1;
                    land_y <= cur.y - 10'(PLAT_HH);
                end
                SCROLL: if (ny >= 11'(SCREEN_H)) begin
                    tbl[idx].x <= rand_x;
                    tbl[idx].y <= 10'(ny - 11'(SCREEN_H));
                end else tbl[idx].y <= ny[9:0];
                default: ;
            endcase
        end

    for (genvar i = 0; i < N_PLAT; i++) begin : g_out
        assign PlatX[i*10 +: 10] = tbl[i].x;
        assign PlatY[i*10 +: 10] = tbl[i].y;
    end
endmodule

// File: tb/tb_platform_table.sv
// tb_platform_table: directed frames against a table-level model of layout, scroll, respawn and landing
module tb_platform_table;
    localparam int N = 16;

    logic          Clk = 0, Reset = 1, frame_clk = 0, ball_falling = 0;
    logic [9:0]    BallX = 0, BallY = 0, Ball_size = 0;
    logic [3:0]    scroll_amt = 0;
    logic [N*10-1:0] PlatX, PlatY;
    logic          table_valid, land, frame_done, overrun;
    logic [9:0]    land_y;

    int checks = 0, errors = 0;
    int mx [N], my [N], init_x [N];
    logic m_valid = 0, m_ovr = 0;
    bit chk_en = 0;
    int cyc = 0;
    logic [15:0] ml = 16'hACE1;
    logic [15:0] hist [8192];
    int done_q [$];

    platform_table dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .BallX(BallX), .BallY(BallY),
        .Ball_size(Ball_size), .ball_falling(ball_falling), .scroll_amt(scroll_amt),
        .PlatX(PlatX), .PlatY(PlatY), .table_valid(table_valid), .land(land), .land_y(land_y),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // hist[c] is the random source value during cycle c after reset release
    always @(posedge Clk)
        if (!Reset) begin
            cyc <= 0;
            ml <= 16'hACE1;
            hist[0] <= 16'hACE1;
        end else begin
            cyc <= cyc + 1;
            ml <= step(ml);
            hist[cyc + 1] <= step(ml);
        end

    always @(negedge Clk) if (frame_done) done_q.push_back(cyc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge Clk)
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("platx[%0d]", i), PlatX[i*10 +: 10], mx[i]);
                chk($sformatf("platy[%0d]", i), PlatY[i*10 +: 10], my[i]);
            end
            chk("table_valid", table_valid, m_valid);
            chk("overrun", overrun, m_ovr);
        end

    task automatic calc_hit(output bit h, output int ly);
        int bx, bys, d;
        h = 0;
        ly = 0;
        bx = BallX;
        bys = BallY + Ball_size;
        for (int i = 0; i < N; i++) begin
            d = bx > mx[i] ? bx - mx[i] : mx[i] - bx;
            if (!h && ball_falling && d <= 4 + Ball_size && bys >= my[i] - 4 && bys <= my[i] + 4) begin
                h = 1;
                ly = (my[i] - 4) & 1023;
            end
        end
    endtask

    // c is the cycle of the first CHECK slot; SCROLL slot i follows 16 cycles later
    task automatic apply_frame(input int c, input int s);
        int ny;
        for (int i = 0; i < N; i++) begin
            ny = my[i] + s;
            if (ny >= 480) begin
                my[i] = ny - 480;
                mx[i] = 64 + hist[c + 16 + i][8:0];
            end else my[i] = ny;
        end
    endtask

    task automatic do_init(input bit first);
        int px;
        chk_en = 0;
        @(negedge Clk);
        Reset = 1;
        repeat (15) @(negedge Clk);
        chk("valid_before_last", table_valid, 0);
        @(negedge Clk);
        for (int i = 0; i < N; i++) begin
            my[i] = 465 - 30 * i;
            mx[i] = 64 + hist[i][8:0];
        end
        m_valid = 1;
        m_ovr = 0;
        chk_en = 1;
        chk("valid_after_init", table_valid, 1);
        chk("platy0_init", PlatY[9:0], 465);
        chk("platy1_init", PlatY[19:10], 435);
        chk("platy15_init", PlatY[159:150], 15);
        for (int i = 0; i < N; i++) begin
            px = PlatX[i*10 +: 10];
            chk($sformatf("platx_range[%0d]", i), px >= 64 && px <= 575, 1);
            if (first) init_x[i] = mx[i];
            else chk($sformatf("relayout_x[%0d]", i), PlatX[i*10 +: 10], init_x[i]);
        end
        if (first) chk("platx0_seed", PlatX[9:0], 289);
    endtask

    task automatic frame(input int s, output int r);
        bit h;
        int ly, t;
        @(negedge Clk);
        chk_en = 0;
        scroll_amt = 4'(s);
        calc_hit(h, ly);
        r = cyc;
        frame_clk = 1;
        t = 0;
        while (!frame_done && t < 100) begin
            @(negedge Clk);
            t++;
            if (t == 10) scroll_amt = 4'hF;
        end
        chk("frame_latency", cyc - r, 35);
        chk("land", land, h);
        if (h) chk("land_y", land_y, ly);
        apply_frame(r + 3, s);
        frame_clk = 0;
        @(negedge Clk);
        chk("frame_done_pulse", frame_done, 0);
        chk("land_pulse", land, 0);
        chk_en = 1;
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, t;
        #2 Reset = 0;
        @(negedge Clk);
        chk("rst_valid", table_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_land", land, 0);
        chk("rst_land_y", land_y, 0);
        chk("rst_platx", |PlatX, 0);
        chk("rst_platy", |PlatY, 0);
        do_init(1);

        frame(10, r);
        chk("platy0_f1", PlatY[9:0], 475);
        chk("platy15_f1", PlatY[159:150], 25);
        for (int i = 0; i < N; i++) chk($sformatf("platx_f1[%0d]", i), PlatX[i*10 +: 10], init_x[i]);

        frame(10, r);
        chk("platy0_wrap", PlatY[9:0], 5);
        chk("platx0_respawn", PlatX[9:0], 64 + hist[r + 19][8:0]);
        for (int i = 1; i < N; i++) chk($sformatf("platx_f2[%0d]", i), PlatX[i*10 +: 10], init_x[i]);

        BallX = 10'(mx[3]);
        Ball_size = 4;
        BallY = 10'(my[3] - 6);
        ball_falling = 1;
        frame(0, r);
        chk("land_y_literal", land_y, 391);
        ball_falling = 0;
        frame(0, r);

        @(negedge Clk);
        chk_en = 0;
        scroll_amt = 3;
        done_q.delete();
        r = cyc;
        for (int k = 0; k < 3; k++) begin
            frame_clk = 1;
            repeat (5) @(negedge Clk);
            frame_clk = 0;
            repeat (5) @(negedge Clk);
        end
        t = 0;
        while (done_q.size() < 2 && t < 200) begin
            @(negedge Clk);
            t++;
        end
        chk("frames_seen", done_q.size(), 2);
        if (done_q.size() >= 2) begin
            chk("first_latency", done_q[0] - r, 35);
            chk("back_to_back_gap", done_q[1] - done_q[0], 33);
        end
        chk("overrun_set", overrun, 1);
        apply_frame(r + 3, 3);
        apply_frame(r + 36, 3);
        m_ovr = 1;
        repeat (2) @(negedge Clk);
        chk_en = 1;
        repeat (40) @(negedge Clk);
        chk("dropped_edge", done_q.size(), 2);

        frame(15, r);

        @(negedge Clk);
        chk_en = 0;
        scroll_amt = 5;
        r = cyc;
        frame_clk = 1;
        repeat (24) @(negedge Clk);
        Reset = 0;
        #1;
        chk("arst_platx", |PlatX, 0);
        chk("arst_platy", |PlatY, 0);
        chk("arst_valid", table_valid, 0);
        chk("arst_land", land, 0);
        chk("arst_land_y", land_y, 0);
        chk("arst_done", frame_done, 0);
        chk("arst_overrun", overrun, 0);
        frame_clk = 0;
        repeat (2) @(negedge Clk);
        do_init(0);
        repeat (3) @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
